// File: rtl/riscv_exec_ctrl_if.sv
// Decoded-instruction handshake between the decoder and the execution sequencer.
interface riscv_exec_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [19:0] in_imm;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_imm, in_rs1, in_rs2, in_rd,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_imm, in_rs1, in_rs2, in_rd,
    output in_ready
  );
endinterface

// File: rtl/riscv_exec_ctrl.sv
// Single-issue sequencer for riscv_insn_exec: owns the integer register file and
// walks each decoded instruction through READ, EXEC and WB.
module riscv_exec_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  riscv_exec_ctrl_if.slave    dec,
  output logic [6:0]          ex_opcode,
  output logic [2:0]          ex_funct3,
  output logic [6:0]          ex_funct7,
  output logic [19:0]         ex_imm,
  output logic [XLEN-1:0]     ex_rs1,
  output logic [XLEN-1:0]     ex_rs2,
  input  logic [XLEN-1:0]     ex_rd,
  output logic                wb_en,
  output logic [4:0]          wb_addr,
  output logic [XLEN-1:0]     wb_data,
  output logic                done,
  output logic                illegal,
  input  logic [4:0]          dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  localparam int unsigned NREGS  = 32;
  localparam logic [6:0]  OP_LUI = 7'b0110111;
  localparam logic [6:0]  OP_REG = 7'b0110011;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t          state;
  logic            in_ready_q;
  logic            accept;
  logic [6:0]      ir_opcode;
  logic [2:0]      ir_funct3;
  logic [6:0]      ir_funct7;
  logic [19:0]     ir_imm;
  logic [4:0]      ir_rs1;
  logic [4:0]      ir_rs2;
  logic [4:0]      ir_rd;
  logic            ir_legal;
  logic [XLEN-1:0] regfile [NREGS];

  // Only encodings whose rd the exec unit actually updates are legal.
  function automatic logic is_legal(input logic [6:0] op, input logic [6:0] f7,
                                    input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (op == OP_LUI) begin
      ok = 1'b1;
    end else if (op == OP_REG) begin
      case ({f7, f3})
        10'b0000000_000, 10'b0100000_000, 10'b0000000_100,
        10'b0000000_110, 10'b0000000_111: ok = 1'b1;
        default:                          ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    return (idx == 5'd0) ? '0 : regfile[idx];
  endfunction

  assign accept       = dec.in_valid && ((state == IDLE) || (state == WB));
  assign dec.in_ready = in_ready_q;
  assign wb_data      = ex_rd;
  assign dbg_data     = rf_read(dbg_addr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      in_ready_q <= 1'b1;
      done       <= 1'b0;
      illegal    <= 1'b0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      ex_opcode  <= '0;
      ex_funct3  <= '0;
      ex_funct7  <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ir_opcode  <= '0;
      ir_funct3  <= '0;
      ir_funct7  <= '0;
      ir_imm     <= '0;
      ir_rs1     <= '0;
      ir_rs2     <= '0;
      ir_rd      <= '0;
      ir_legal   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regfile[i] <= '0;
    end else begin
      // Pulses and exec drive default low so the exec unit holds rd outside EXEC.
      done      <= 1'b0;
      illegal   <= 1'b0;
      wb_en     <= 1'b0;
      ex_opcode <= '0;
      ex_funct3 <= '0;
      ex_funct7 <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;

      if (accept) begin
        ir_opcode <= dec.in_opcode;
        ir_funct3 <= dec.in_funct3;
        ir_funct7 <= dec.in_funct7;
        ir_imm    <= dec.in_imm;
        ir_rs1    <= dec.in_rs1;
        ir_rs2    <= dec.in_rs2;
        ir_rd     <= dec.in_rd;
        ir_legal  <= is_legal(dec.in_opcode, dec.in_funct7, dec.in_funct3);
      end

      // Commit on the WB edge so the following READ observes the new value.
      if ((state == WB) && wb_en) regfile[wb_addr] <= ex_rd;

      case (state)
        IDLE: begin
          if (dec.in_valid) begin
            state      <= READ;
            in_ready_q <= 1'b0;
          end
        end
        READ: begin
          ex_opcode <= ir_legal ? ir_opcode : 7'd0;
          ex_funct3 <= ir_funct3;
          ex_funct7 <= ir_funct7;
          ex_imm    <= ir_imm;
          ex_rs1    <= rf_read(ir_rs1);
          ex_rs2    <= rf_read(ir_rs2);
          state     <= EXEC;
        end
        EXEC: begin
          done       <= 1'b1;
          illegal    <= !ir_legal;
          wb_en      <= ir_legal && (ir_rd != 5'd0);
          wb_addr    <= ir_rd;
          in_ready_q <= 1'b1;
          state      <= WB;
        end
        WB: begin
          if (dec.in_valid) begin
            state      <= READ;
            in_ready_q <= 1'b0;
          end else begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_exec_ctrl.md
# riscv_exec_ctrl

Single-issue sequencer for `riscv_insn_exec`. It owns the 32-entry integer register file and accepts decoded instructions over a valid/ready handshake. For each instruction it reads the operands, drives the execution unit for exactly one cycle, and writes back the registered result. Unsupported encodings are flagged and retired without writeback.

## Interface

Parameters:
- `XLEN`, default 32: datapath width. Must be ≥ 20.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: controller can accept an instruction this cycle.
- `in_opcode` in 7, `in_funct3` in 3, `in_funct7` in 7, `in_imm` in 20: decoded fields.
- `in_rs1`, `in_rs2`, `in_rd` in 5 each: register indices.
- `ex_opcode` out 7, `ex_funct3` out 3, `ex_funct7` out 7, `ex_imm` out 20: fields driven to the exec unit.
- `ex_rs1`, `ex_rs2` out XLEN: operand values driven to the exec unit.
- `ex_rd` in XLEN: registered result from the exec unit.
- `wb_en` out 1, `wb_addr` out 5, `wb_data` out XLEN: writeback strobe, mirrored for trace.
- `done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: one-cycle pulse, coincident with `done`, for an unsupported encoding.
- `dbg_addr` in 5, `dbg_data` out XLEN: combinational register-file read port for the bench.

## Operation

- **Supported set:**
  - `lui`: opcode 0110111.
  - opcode 0110011 with {funct7, funct3} equal to:
    - `add` 0000000_000
    - `sub` 0100000_000
    - `xor` 0000000_100
    - `or` 0000000_110
    - `and` 0000000_111
  - Every other encoding is illegal. This includes `sll`, `slt`, `sltu`, `srl` and `sra`, because the exec unit leaves `rd` stale for them.
- **FSM states:** IDLE, READ, EXEC, WB. Reset state is IDLE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`: capture all `in_*` fields into an instruction register, compute the legal flag, go to READ.
- **READ:**
  - Latch regfile[rs1] and regfile[rs2] into operand registers. Index 0 reads as 0.
  - Go to EXEC.
- **EXEC:**
  - Drive `ex_*` from the captured fields and operand registers.
  - If the instruction is illegal, drive `ex_opcode`=0 instead.
  - Go to WB.
- **WB:**
  - Assert `done`.
  - If legal and rd≠0: assert `wb_en` and write `ex_rd` into regfile[rd] at the end of the cycle.
  - If illegal: assert `illegal`, no write.
  - `wb_addr` = captured rd and `wb_data` = `ex_rd`, in every WB cycle.
  - `in_ready`=1. On `in_valid`, capture the next instruction and go to READ; otherwise go to IDLE.
- **Outside EXEC:** `ex_opcode`=0 and all other `ex_*` outputs = 0, so the exec unit holds its `rd`.
- **x0:** never written, always reads 0 on both the operand reads and `dbg_data`.
- **Read-after-write:** a WB write followed by the READ of the next instruction sees the new value. The write commits on the WB→READ edge, before the READ-cycle sample.
- **`in_*` outside handshake:** ignored except in IDLE and WB.

## Timing

- **Latency:** handshake at edge 0 → READ, EXEC, WB cycles. `done` is high during the third cycle after acceptance. The regfile is updated at the edge ending WB.
- **Throughput:** one instruction per 3 cycles under back-to-back `in_valid` (accept in WB).
- **`ex_rd` sampling:** the exec unit registers `rd` at the edge ending EXEC. The controller uses `ex_rd` combinationally during WB.
- **Reset values:** state=IDLE, `in_ready`=1 (combinational from state), `done`=0, `illegal`=0, `wb_en`=0, `wb_addr`=0, `wb_data` is don't-care outside WB, all `ex_*`=0, all regfile entries=0, instruction and operand registers=0.
- **Reset mid-operation:** asserting `reset_n` low in any state aborts the in-flight instruction. There is no `done` pulse and no regfile write, including in WB. After release the controller is in IDLE.
- All outputs except `dbg_data` are derived from registered state. `in_ready` has no combinational path from `in_valid`.

## Test plan

- **Reset:** hold `reset_n`=0 for 3 cycles, release. `in_ready`=1, `done`=0, `dbg_data`=0 for all 32 `dbg_addr`.
- **LUI then ADD:** `lui` x1 imm=0x12345, then `add` x3=x1+x1. x1=0x00012345, x3=0x0002468A. Each `done` arrives 3 cycles after its accept.
- **SUB/XOR/OR/AND:**
  - Preload x1=0x0000F0F0 and x2=0x00000FF0 via `lui`.
  - `sub` x4 gives 0x0000E100. `xor` gives 0x0000FF00. `or` gives 0x0000FFF0. `and` gives 0x000000F0.
- **x0 and illegal:**
  - `add` x0=x1+x1 → `done`=1, `wb_en`=0, x0 reads 0.
  - `sll` x5 (funct10 0000000_001) → `illegal`=1, `wb_en`=0, x5 unchanged, `ex_opcode` held 0.
- **Back-to-back RAW:** hold `in_valid` high with `lui` x6 imm=0x1, then `add` x7=x6+x6. The second accept happens in WB, `done` pulses are 3 cycles apart, and x7=0x00000002.
- **Reset mid-op:** assert `reset_n` low during EXEC of `lui` x8 imm=0xABCDE. No `done`, x8=0, and the next accepted instruction completes normally.
